cyber_player: RTL and testbench

//  Computer opponent for the Tug of War game. Produces pressR for the playfield
//  as single-cycle press pulses, replacing the human right-hand button.
//  - Pseudo-random press rate from an LFSR compared against the SW difficulty setting.
//  - Paced by an internal tick divider.
//  - Silent whenever the game is not active.

---
 rtl/cyber_player_if.sv | 25 ++
 rtl/cyber_player.sv | 105 ++++++++++
 tb/tb_cyber_player.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/cyber_player_if.sv
// Signal bundle between the Tug of War playfield side and the computer opponent.
// The opponent (slave) receives the game controls and returns its press pulse and status.
interface cyber_player_if;
    logic       enable;
    logic [9:0] difficulty;
    logic       press;
    logic [9:0] lfsr_q;
    logic [7:0] press_count;

    modport master (
        output enable,
        output difficulty,
        input  press,
        input  lfsr_q,
        input  press_count
    );

    modport slave (
        input  enable,
        input  difficulty,
        output press,
        output lfsr_q,
        output press_count
    );
endinterface

// File: rtl/cyber_player.sv
// Computer opponent for Tug of War: emits single-cycle press pulses at a pseudo-random
// rate set by an LFSR compared against the difficulty switches, paced by a tick divider.
module cyber_player #(
    parameter int TICK_DIV = 2**20,
    parameter int MIN_GAP  = 2
) (
    input  logic          clk,
    input  logic          reset,
    cyber_player_if.slave bus
);
    localparam int TICK_W = $clog2(TICK_DIV);
    localparam int GAP_W  = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(MIN_GAP - 1);

    typedef enum logic [1:0] {IDLE, COUNT, FIRE, HOLDOFF} state_t;

    state_t              state_q, state_d;
    logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [GAP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic [9:0]          lfsr_q, lfsr_d;
    logic                press_q, press_d;
    logic [7:0]          press_count_q, press_count_d;
    logic [9:0]          lfsr_next;

    // XNOR feedback makes all-zero a legal start; 3FF is the unreachable lockup state.
    assign lfsr_next = {lfsr_q[8:0], ~(lfsr_q[9] ^ lfsr_q[6])};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            tick_cnt_q    <= '0;
            gap_cnt_q     <= '0;
            lfsr_q        <= '0;
            press_q       <= 1'b0;
            press_count_q <= '0;
        end else begin
            state_q       <= state_d;
            tick_cnt_q    <= tick_cnt_d;
            gap_cnt_q     <= gap_cnt_d;
            lfsr_q        <= lfsr_d;
            press_q       <= press_d;
            press_count_q <= press_count_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        tick_cnt_d    = tick_cnt_q;
        gap_cnt_d     = gap_cnt_q;
        lfsr_d        = lfsr_q;
        press_d       = (state_q == FIRE);
        press_count_d = press_count_q;

        if (state_q == FIRE && press_count_q != 8'hFF) begin
            press_count_d = press_count_q + 8'd1;
        end

        case (state_q)
            IDLE: begin
                tick_cnt_d = '0;
                gap_cnt_d  = '0;
                if (bus.enable) begin
                    state_d = COUNT;
                end
            end
            COUNT: begin
                if (tick_cnt_q == TICK_LAST) begin
                    tick_cnt_d = '0;
                    lfsr_d     = lfsr_next;
                    if (lfsr_next < bus.difficulty) begin
                        state_d = FIRE;
                    end
                end else begin
                    tick_cnt_d = tick_cnt_q + 1'b1;
                end
            end
            FIRE: begin
                state_d   = HOLDOFF;
                gap_cnt_d = '0;
            end
            HOLDOFF: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d    = COUNT;
                    tick_cnt_d = '0;
                end else begin
                    gap_cnt_d = gap_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Leaving the game freezes the LFSR; a FIRE already entered still pulses via press_d.
        if (!bus.enable) begin
            state_d    = IDLE;
            tick_cnt_d = '0;
            gap_cnt_d  = '0;
            lfsr_d     = lfsr_q;
        end
    end

    assign bus.press       = press_q;
    assign bus.lfsr_q      = lfsr_q;
    assign bus.press_count = press_count_q;
endmodule

// File: tb/tb_cyber_player.sv
// Directed bench for cyber_player with TICK_DIV=4, MIN_GAP=2: a cycle table for reset and
// the first presses, then hand sequences for difficulty extremes, enable drop and saturation.
module tb_cyber_player;
    logic clk;
    logic reset;
    int   pass_cnt;
    int   total_cnt;

    cyber_player_if bus_if();

    cyber_player #(
        .TICK_DIV(4),
        .MIN_GAP (2)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus_if.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic       rst;
        logic       en;
        logic [9:0] diff;
        int         cycles;
        logic       press;
        logic [9:0] lfsr;
        logic [7:0] cnt;
    } vec_t;

    vec_t vecs[14];

    function automatic logic [9:0] lfsr_step(input logic [9:0] l);
        return {l[8:0], ~(l[9] ^ l[6])};
    endfunction

    task automatic applyStimulus(input logic rst, input logic en, input logic [9:0] diff);
        reset             = rst;
        bus_if.enable     = en;
        bus_if.difficulty = diff;
    endtask

    task automatic checkOutput(input string name, input int idx,
                               input logic [31:0] actual, input logic [31:0] expected);
        total_cnt++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s[%0d]: got %0h, expected %0h", name, idx, actual, expected);
        end else begin
            pass_cnt++;
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [9:0] exp_l;
        logic [9:0] held_l;
        logic [7:0] held_c;
        int         npress;
        int         last;
        logic       prev_press;
        logic       found;

        pass_cnt  = 0;
        total_cnt = 0;
        applyStimulus(1'b1, 1'b0, 10'd4);

        vecs[0]  = '{1'b1, 1'b0, 10'd4,  2, 1'b0, 10'h000, 8'd0};
        vecs[1]  = '{1'b0, 1'b0, 10'd4, 20, 1'b0, 10'h000, 8'd0};
        vecs[2]  = '{1'b0, 1'b1, 10'd4,  4, 1'b0, 10'h000, 8'd0};
        vecs[3]  = '{1'b0, 1'b1, 10'd4,  1, 1'b0, 10'h001, 8'd0};
        vecs[4]  = '{1'b0, 1'b1, 10'd4,  1, 1'b1, 10'h001, 8'd1};
        vecs[5]  = '{1'b0, 1'b1, 10'd4,  1, 1'b0, 10'h001, 8'd1};
        vecs[6]  = '{1'b0, 1'b1, 10'd4,  4, 1'b0, 10'h001, 8'd1};
        vecs[7]  = '{1'b0, 1'b1, 10'd4,  1, 1'b0, 10'h003, 8'd1};
        vecs[8]  = '{1'b0, 1'b1, 10'd4,  1, 1'b1, 10'h003, 8'd2};
        vecs[9]  = '{1'b0, 1'b1, 10'd4,  1, 1'b0, 10'h003, 8'd2};
        vecs[10] = '{1'b0, 1'b1, 10'd4,  4, 1'b0, 10'h003, 8'd2};
        vecs[11] = '{1'b0, 1'b1, 10'd4,  1, 1'b0, 10'h007, 8'd2};
        vecs[12] = '{1'b0, 1'b1, 10'd4,  4, 1'b0, 10'h00F, 8'd2};
        vecs[13] = '{1'b0, 1'b1, 10'd4,  4, 1'b0, 10'h01F, 8'd2};

        @(negedge clk);
        for (int v = 0; v < 14; v++) begin
            applyStimulus(vecs[v].rst, vecs[v].en, vecs[v].diff);
            for (int c = 1; c <= vecs[v].cycles; c++) begin
                step();
                if (c < vecs[v].cycles) begin
                    checkOutput("tbl_press_between", v, 32'(bus_if.press), 32'd0);
                end
            end
            checkOutput("tbl_press", v, 32'(bus_if.press), 32'(vecs[v].press));
            checkOutput("tbl_lfsr", v, 32'(bus_if.lfsr_q), 32'(vecs[v].lfsr));
            checkOutput("tbl_count", v, 32'(bus_if.press_count), 32'(vecs[v].cnt));
        end

        // difficulty 0: LFSR keeps ticking every 4 cycles, never a press
        exp_l = 10'h01F;
        applyStimulus(1'b0, 1'b1, 10'd0);
        for (int i = 1; i <= 100; i++) begin
            step();
            if (i % 4 == 0) exp_l = lfsr_step(exp_l);
            checkOutput("d0_press", i, 32'(bus_if.press), 32'd0);
            checkOutput("d0_lfsr", i, 32'(bus_if.lfsr_q), 32'(exp_l));
        end
        checkOutput("d0_count", 0, 32'(bus_if.press_count), 32'd2);

        // difficulty 3FF: a press every 7 cycles
        applyStimulus(1'b0, 1'b1, 10'h3FF);
        npress     = 0;
        last       = 0;
        prev_press = 1'b0;
        for (int i = 1; i <= 42; i++) begin
            step();
            if (bus_if.press) begin
                checkOutput("max_no_double", i, 32'(prev_press), 32'd0);
                if (npress == 0) checkOutput("max_first_press", i, 32'(i), 32'd5);
                else             checkOutput("max_press_gap", i, 32'(i - last), 32'd7);
                last = i;
                npress++;
            end
            prev_press = bus_if.press;
        end
        checkOutput("max_npress", 0, 32'(npress), 32'd6);
        checkOutput("max_count", 0, 32'(bus_if.press_count), 32'd8);

        // drop enable in HOLDOFF, re-raise after 5 cycles
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (bus_if.press) found = 1'b1;
        end
        checkOutput("en_wait_press", 0, 32'(found), 32'd1);
        held_l = bus_if.lfsr_q;
        held_c = bus_if.press_count;
        applyStimulus(1'b0, 1'b0, 10'h3FF);
        for (int i = 1; i <= 5; i++) begin
            step();
            checkOutput("en_off_press", i, 32'(bus_if.press), 32'd0);
            checkOutput("en_off_lfsr", i, 32'(bus_if.lfsr_q), 32'(held_l));
        end
        applyStimulus(1'b0, 1'b1, 10'h3FF);
        for (int j = 1; j <= 6; j++) begin
            step();
            checkOutput("en_on_press", j, 32'(bus_if.press), (j == 6) ? 32'd1 : 32'd0);
            checkOutput("en_on_lfsr", j, 32'(bus_if.lfsr_q),
                        (j >= 5) ? 32'(lfsr_step(held_l)) : 32'(held_l));
        end
        checkOutput("en_count", 0, 32'(bus_if.press_count), 32'(held_c) + 32'd1);

        // reset on the FIRE cycle: the cycle right after a tick moved the LFSR
        held_l = bus_if.lfsr_q;
        found  = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            step();
            if (bus_if.lfsr_q != held_l) found = 1'b1;
        end
        checkOutput("rst_wait_fire", 0, 32'(found), 32'd1);
        applyStimulus(1'b1, 1'b1, 10'h3FF);
        step();
        checkOutput("rst_press", 0, 32'(bus_if.press), 32'd0);
        checkOutput("rst_lfsr", 0, 32'(bus_if.lfsr_q), 32'd0);
        checkOutput("rst_count", 0, 32'(bus_if.press_count), 32'd0);
        applyStimulus(1'b0, 1'b1, 10'h3FF);

        // 300 presses: count saturates at FF
        npress     = 0;
        prev_press = 1'b0;
        for (int i = 0; i < 3000 && npress < 300; i++) begin
            step();
            if (bus_if.press) begin
                npress++;
                if (prev_press) checkOutput("sat_no_double", npress, 32'd1, 32'd0);
                if (npress == 1)   checkOutput("sat_first", i, 32'(i), 32'd5);
                if (npress == 254) checkOutput("sat_count254", 0, 32'(bus_if.press_count), 32'd254);
                if (npress == 255) checkOutput("sat_count255", 0, 32'(bus_if.press_count), 32'd255);
            end
            prev_press = bus_if.press;
        end
        checkOutput("sat_npress", 0, 32'(npress), 32'd300);
        checkOutput("sat_count", 0, 32'(bus_if.press_count), 32'hFF);
        for (int i = 0; i < 10; i++) step();
        checkOutput("sat_hold", 0, 32'(bus_if.press_count), 32'hFF);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
